// File: rtl/ss_driver_pkg.sv
// Shared constants for the multiplexed seven-segment display driver.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package ss_driver_pkg;

  localparam int unsigned DIGIT_PERIOD_DEF = 100000;
  localparam int unsigned SLOT_W           = 20;
  localparam int unsigned SEG_W            = 7;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F = 7'h0E;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] DIGIT_OFF = 8'hFF;

endpackage

// File: rtl/seg_decoder.sv
// Hex digit to active-low seven-segment pattern, purely combinational.
module seg_decoder
  import ss_driver_pkg::*;
(
  input  logic [3:0]       bcd,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_8;
    case (bcd)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_8;
    endcase
  end

endmodule

// File: rtl/ss_driver.sv
// Four-digit multiplexed seven-segment driver with PWM brightness control.
// Digit scan and PWM compare share one registered output stage.
module ss_driver
  import ss_driver_pkg::*;
#(
  parameter int unsigned DIGIT_PERIOD = DIGIT_PERIOD_DEF
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic [3:0] BCD3,
  input  logic [3:0] BCD2,
  input  logic [3:0] BCD1,
  input  logic [3:0] BCD0,
  input  logic [7:0] PWM,
  output logic [7:0] SegmentDrivers,
  output logic [7:0] SevenSegment
);

  logic [SLOT_W-1:0] slot_cnt;
  logic [1:0]        digit_idx;
  logic [7:0]        pwm_cnt;
  logic [3:0]        bcd_sel;
  logic [SEG_W-1:0]  seg_raw;
  logic              slot_wrap;
  logic              lit;
  logic [7:0]        drivers_nxt;
  logic [7:0]        segments_nxt;

  // Slot end detect, brightness gate and digit select
  always_comb begin
    slot_wrap = (slot_cnt == SLOT_W'(DIGIT_PERIOD - 1));
    lit       = (pwm_cnt < PWM);
    bcd_sel   = BCD0;
    case (digit_idx)
      2'd0:    bcd_sel = BCD0;
      2'd1:    bcd_sel = BCD1;
      2'd2:    bcd_sel = BCD2;
      2'd3:    bcd_sel = BCD3;
      default: bcd_sel = BCD0;
    endcase
  end

  seg_decoder u_seg_decoder (
    .bcd (bcd_sel),
    .seg (seg_raw)
  );

  // Blank both buses when unlit so a digit change never ghosts
  always_comb begin
    drivers_nxt  = DIGIT_OFF;
    segments_nxt = SEG_BLANK;
    if (lit) begin
      drivers_nxt[digit_idx] = 1'b0;
      segments_nxt           = {1'b1, seg_raw};
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!reset) begin
      slot_cnt       <= '0;
      digit_idx      <= 2'd0;
      pwm_cnt        <= 8'd0;
      SegmentDrivers <= DIGIT_OFF;
      SevenSegment   <= SEG_BLANK;
    end else begin
      slot_cnt       <= slot_wrap ? '0 : slot_cnt + SLOT_W'(1);
      if (slot_wrap) begin
        digit_idx <= digit_idx + 2'd1;
      end
      pwm_cnt        <= pwm_cnt + 8'd1;
      SegmentDrivers <= drivers_nxt;
      SevenSegment   <= segments_nxt;
    end
  end

endmodule

// File: tb/tb_ss_driver.sv
// Directed self-checking bench for ss_driver: a short-slot instance for scan/PWM
// behaviour and a longer-slot instance for decode sweep and mid-slot updates.
module tb_ss_driver;

  logic       clk;
  logic       reset;
  logic [3:0] bcd3, bcd2, bcd1, bcd0;
  logic [7:0] pwm;
  logic [7:0] fast_sd, fast_ss, slow_sd, slow_ss;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_sd_tab [4]  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
  logic [7:0] exp_ss_tab [4]  = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
  logic [7:0] sweep_tab  [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  ss_driver #(.DIGIT_PERIOD(4)) u_fast (
    .CLK100MHZ      (clk),
    .reset          (reset),
    .BCD3           (bcd3),
    .BCD2           (bcd2),
    .BCD1           (bcd1),
    .BCD0           (bcd0),
    .PWM            (pwm),
    .SegmentDrivers (fast_sd),
    .SevenSegment   (fast_ss)
  );

  ss_driver #(.DIGIT_PERIOD(64)) u_slow (
    .CLK100MHZ      (clk),
    .reset          (reset),
    .BCD3           (bcd3),
    .BCD2           (bcd2),
    .BCD1           (bcd1),
    .BCD0           (bcd0),
    .PWM            (pwm),
    .SegmentDrivers (slow_sd),
    .SevenSegment   (slow_ss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int lit_cnt;
    int bad_sd;
    int bad_ss;
    logic [7:0] e_sd;
    logic [7:0] e_ss;

    reset = 1'b0;
    pwm   = 8'd255;
    bcd3  = 4'd1;
    bcd2  = 4'd2;
    bcd1  = 4'd3;
    bcd0  = 4'd4;
    repeat (3) step();
    check("reset_fast_sd", 32'(fast_sd), 32'hFF);
    check("reset_fast_ss", 32'(fast_ss), 32'hFF);
    check("reset_slow_sd", 32'(slow_sd), 32'hFF);
    check("reset_slow_ss", 32'(slow_ss), 32'hFF);

    // Full-brightness scan: digit index advances every 4 cycles, dark only at pwm_counter=255
    reset = 1'b1;
    for (int k = 0; k < 256; k++) begin
      step();
      e_sd = (k < 255) ? exp_sd_tab[(k / 4) % 4] : 8'hFF;
      e_ss = (k < 255) ? exp_ss_tab[(k / 4) % 4] : 8'hFF;
      check("scan255_sd", 32'(fast_sd), 32'(e_sd));
      check("scan255_ss", 32'(fast_ss), 32'(e_ss));
    end

    // Quarter duty: lit only while pwm_counter is 0..63
    pwm     = 8'd64;
    lit_cnt = 0;
    for (int k = 256; k < 512; k++) begin
      step();
      e_sd = ((k % 256) < 64) ? exp_sd_tab[(k / 4) % 4] : 8'hFF;
      e_ss = ((k % 256) < 64) ? exp_ss_tab[(k / 4) % 4] : 8'hFF;
      check("pwm64_sd", 32'(fast_sd), 32'(e_sd));
      check("pwm64_ss", 32'(fast_ss), 32'(e_ss));
      if (fast_sd != 8'hFF) lit_cnt++;
    end
    check("pwm64_lit_count", 32'(lit_cnt), 32'd64);

    // Zero duty: never lit
    pwm    = 8'd0;
    bad_sd = 0;
    bad_ss = 0;
    for (int k = 512; k < 1536; k++) begin
      step();
      if (fast_sd != 8'hFF || slow_sd != 8'hFF) bad_sd++;
      if (fast_ss != 8'hFF || slow_ss != 8'hFF) bad_ss++;
    end
    check("pwm0_sd_lit_cycles", 32'(bad_sd), 32'd0);
    check("pwm0_ss_lit_cycles", 32'(bad_ss), 32'd0);

    // Advance to the middle of digit 2 on the short-slot instance
    pwm = 8'd255;
    repeat (10) step();
    check("digit2_sd", 32'(fast_sd), 32'hFB);
    check("digit2_ss", 32'(fast_ss), 32'hA4);

    reset = 1'b0;
    step();
    check("midscan_reset_fast_sd", 32'(fast_sd), 32'hFF);
    check("midscan_reset_fast_ss", 32'(fast_ss), 32'hFF);
    check("midscan_reset_slow_sd", 32'(slow_sd), 32'hFF);
    check("midscan_reset_slow_ss", 32'(slow_ss), 32'hFF);

    // Restart at digit 0 with a full slot; sweep BCD0 through every code on the long slot
    reset = 1'b1;
    for (int v = 0; v < 16; v++) begin
      bcd0 = 4'(v);
      step();
      check("sweep_slow_ss", 32'(slow_ss), 32'(sweep_tab[v]));
      check("sweep_slow_sd", 32'(slow_sd), 32'hFE);
      check("restart_fast_sd", 32'(fast_sd), 32'(exp_sd_tab[v / 4]));
    end

    // Mid-slot change on digit 1 of the long-slot instance (cycle 80 after release)
    bcd1 = 4'd5;
    repeat (65) step();
    check("midslot_before_ss", 32'(slow_ss), 32'h92);
    check("midslot_before_sd", 32'(slow_sd), 32'hFD);
    bcd1 = 4'd9;
    step();
    check("midslot_after_ss", 32'(slow_ss), 32'h90);
    check("midslot_after_sd", 32'(slow_sd), 32'hFD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
